// File: rtl/mode_output_sequencer.sv
// Mode selector for a gated-output unit: a debounced push button steps through
// operating modes (long press returns to mode 0), channel outputs follow a
// per-mode static pattern or the timing generator, and an LED blinks the mode.
module mode_output_sequencer #(
    parameter int unsigned                 NUM_MODES        = 5,
    parameter int unsigned                 NUM_CH           = 4,
    parameter logic [NUM_MODES*NUM_CH-1:0] MODE_PATTERNS    = 20'hFA539,
    parameter logic [NUM_MODES-1:0]        PASSTHRU_MASK    = 5'b00010,
    parameter int unsigned                 DEBOUNCE_DIV     = 256,
    parameter int unsigned                 DEBOUNCE_SAMPLES = 4,
    parameter int unsigned                 HOLD_TICKS       = 20000,
    parameter int unsigned                 FLASH_ON         = 1000,
    parameter int unsigned                 FLASH_OFF        = 1000,
    parameter int unsigned                 PAUSE            = 5000
) (
    input  logic                         clk_2M5,
    input  logic                         reset,
    input  logic                         mode_button,
    input  logic [NUM_CH-1:0]            timer_ch,
    output logic [NUM_CH-1:0]            ch_out,
    output logic                         LED_output,
    output logic [$clog2(NUM_MODES)-1:0] mode,
    output logic                         mode_changed
);

    localparam int unsigned MODE_W  = $clog2(NUM_MODES);
    localparam int unsigned DIV_W   = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int unsigned SMP_W   = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int unsigned LED_MAX = (PAUSE > FLASH_ON) ? ((PAUSE > FLASH_OFF) ? PAUSE : FLASH_OFF)
                                                         : ((FLASH_ON > FLASH_OFF) ? FLASH_ON : FLASH_OFF);
    localparam int unsigned LED_W   = $clog2(LED_MAX + 1);
    localparam int unsigned FLASH_W = $clog2(NUM_MODES + 1);

    typedef enum logic [1:0] {
        LED_START,
        LED_ON,
        LED_OFF,
        LED_PAUSE
    } led_state_t;

    logic                r_sync1, r_sync2;
    logic                r_armed;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_db_level;
    logic [SMP_W-1:0]    r_db_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [MODE_W-1:0]   r_mode;
    logic                r_mode_changed;
    logic [NUM_CH-1:0]   r_ch_out;
    led_state_t          r_led_state, w_led_state_nx;
    logic [LED_W-1:0]    r_led_cnt, w_led_cnt_nx;
    logic [FLASH_W-1:0]  r_flash_cnt, w_flash_cnt_nx;
    logic                r_led, w_led_nx;

    logic                w_tick, w_sample, w_flip, w_release, w_hold_hit, w_mode_upd;
    logic [NUM_CH-1:0]   w_pat;
    logic                w_pass;

    // Sample tick, debounce and press-event decode
    assign w_tick     = (r_div_cnt == DIV_W'(DEBOUNCE_DIV - 1));
    assign w_sample   = r_sync2 & r_armed;
    assign w_flip     = w_tick & (w_sample != r_db_level) & (r_db_cnt == SMP_W'(DEBOUNCE_SAMPLES - 1));
    assign w_release  = w_flip & r_db_level;
    assign w_hold_hit = w_tick & r_db_level & ~w_flip & (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1));
    assign w_mode_upd = (w_release & (r_hold_cnt != HOLD_W'(HOLD_TICKS))) | w_hold_hit;

    // Synchronise the button (stored as pressed=1); ignore a press already held out of reset
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= ~mode_button;
            r_sync2 <= r_sync1;
            if (w_tick && !r_sync2)
                r_armed <= 1'b1;
        end
    end

    // Free-running prescaler and consecutive-sample debouncer
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                if (w_flip) begin
                    r_db_level <= w_sample;
                    r_db_cnt   <= '0;
                end else if (w_sample != r_db_level) begin
                    r_db_cnt <= r_db_cnt + SMP_W'(1);
                end else begin
                    r_db_cnt <= '0;
                end
            end
        end
    end

    // Hold counter and mode register: short press advances, long press returns to 0
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_hold_cnt     <= '0;
            r_mode         <= '0;
            r_mode_changed <= 1'b0;
        end else begin
            r_mode_changed <= w_mode_upd;
            if (w_tick) begin
                if (r_db_level && !w_flip) begin
                    if (r_hold_cnt != HOLD_W'(HOLD_TICKS))
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end else begin
                    r_hold_cnt <= '0;
                end
            end
            if (w_hold_hit)
                r_mode <= '0;
            else if (w_mode_upd)
                r_mode <= (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + MODE_W'(1);
        end
    end

    // Per-mode pattern and passthrough selection
    always_comb begin
        w_pat  = '0;
        w_pass = 1'b0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (r_mode == MODE_W'(m)) begin
                w_pat  = MODE_PATTERNS[m*NUM_CH +: NUM_CH];
                w_pass = PASSTHRU_MASK[m];
            end
        end
    end

    // Registered channel outputs
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset)
            r_ch_out <= '0;
        else
            r_ch_out <= w_pass ? timer_ch : w_pat;
    end

    // LED sequencer state register
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_led_state <= LED_START;
            r_led_cnt   <= '0;
            r_flash_cnt <= '0;
            r_led       <= 1'b0;
        end else begin
            r_led_state <= w_led_state_nx;
            r_led_cnt   <= w_led_cnt_nx;
            r_flash_cnt <= w_flash_cnt_nx;
            r_led       <= w_led_nx;
        end
    end

    // LED sequencer next state: (mode+1) flashes then a pause; restart dark on mode change
    always_comb begin
        w_led_state_nx = r_led_state;
        w_led_cnt_nx   = r_led_cnt;
        w_flash_cnt_nx = r_flash_cnt;
        w_led_nx       = r_led;
        if (w_mode_upd) begin
            w_led_state_nx = LED_START;
            w_led_cnt_nx   = '0;
            w_flash_cnt_nx = '0;
            w_led_nx       = 1'b0;
        end else if (w_tick) begin
            case (r_led_state)
                LED_START: begin
                    w_led_state_nx = LED_ON;
                    w_led_cnt_nx   = '0;
                    w_flash_cnt_nx = '0;
                    w_led_nx       = 1'b1;
                end
                LED_ON: begin
                    if (r_led_cnt == LED_W'(FLASH_ON - 1)) begin
                        w_led_state_nx = LED_OFF;
                        w_led_cnt_nx   = '0;
                        w_led_nx       = 1'b0;
                    end else begin
                        w_led_cnt_nx = r_led_cnt + LED_W'(1);
                    end
                end
                LED_OFF: begin
                    if (r_led_cnt == LED_W'(FLASH_OFF - 1)) begin
                        w_led_cnt_nx = '0;
                        if (r_flash_cnt == FLASH_W'(r_mode)) begin
                            w_led_state_nx = LED_PAUSE;
                        end else begin
                            w_led_state_nx = LED_ON;
                            w_flash_cnt_nx = r_flash_cnt + FLASH_W'(1);
                            w_led_nx       = 1'b1;
                        end
                    end else begin
                        w_led_cnt_nx = r_led_cnt + LED_W'(1);
                    end
                end
                LED_PAUSE: begin
                    if (r_led_cnt == LED_W'(PAUSE - 1)) begin
                        w_led_state_nx = LED_ON;
                        w_led_cnt_nx   = '0;
                        w_flash_cnt_nx = '0;
                        w_led_nx       = 1'b1;
                    end else begin
                        w_led_cnt_nx = r_led_cnt + LED_W'(1);
                    end
                end
                default: begin
                    w_led_state_nx = LED_START;
                    w_led_cnt_nx   = '0;
                    w_flash_cnt_nx = '0;
                    w_led_nx       = 1'b0;
                end
            endcase
        end
    end

    assign ch_out       = r_ch_out;
    assign LED_output   = r_led;
    assign mode         = r_mode;
    assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_mode_output_sequencer.sv
// Bench for mode_output_sequencer: tick-level behavioural model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_mode_output_sequencer;

    localparam int NM = 5, NC = 4, DIV = 4, SMP = 3, HOLD = 20;
    localparam int FON = 2, FOFF = 2, FPAUSE = 6;
    localparam logic [19:0] PAT  = 20'hFA539;
    localparam logic [4:0]  PASS = 5'b00010;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [3:0] tch;
    logic [3:0] ch_out;
    logic       led;
    logic [2:0] mode;
    logic       chg;

    int checks = 0;
    int failures = 0;
    int n_pulse = 0;
    bit cmp_en = 1'b0;

    mode_output_sequencer #(
        .NUM_MODES(NM), .NUM_CH(NC), .MODE_PATTERNS(PAT), .PASSTHRU_MASK(PASS),
        .DEBOUNCE_DIV(DIV), .DEBOUNCE_SAMPLES(SMP), .HOLD_TICKS(HOLD),
        .FLASH_ON(FON), .FLASH_OFF(FOFF), .PAUSE(FPAUSE)
    ) dut (
        .clk_2M5(clk), .reset(rst), .mode_button(btn), .timer_ch(tch),
        .ch_out(ch_out), .LED_output(led), .mode(mode), .mode_changed(chg)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pat_of(int m);
        return 4'(PAT >> (m * NC));
    endfunction

    function automatic logic pass_of(int m);
        return ((PASS >> m) & 5'd1) != 5'd0;
    endfunction

    // LED level for the q-th tick after a restart (q counts from 0)
    function automatic logic led_of(int q, int m);
        int flash_len, per, r;
        flash_len = (m + 1) * (FON + FOFF);
        per = flash_len + FPAUSE;
        r = q % per;
        return (r < flash_len) && ((r % (FON + FOFF)) < FON);
    endfunction

    // Behavioural model state
    int         m_div, m_run, m_hold, m_mode, m_k;
    bit         m_s1, m_s2, m_level, m_armed, m_chg, m_led;
    logic [3:0] m_ch;

    always @(posedge clk or posedge rst) begin : model
        bit tick, samp, eff, chg_n, released, pressed_old;
        int old_mode;
        if (rst) begin
            m_div = 0; m_run = 0; m_hold = 0; m_mode = 0; m_k = 0;
            m_s1 = 0; m_s2 = 0; m_level = 0; m_armed = 0; m_chg = 0; m_led = 0;
            m_ch = 4'h0;
        end else begin
            tick = (m_div == DIV - 1);
            m_div = (m_div + 1) % DIV;
            samp = m_s2;
            m_s2 = m_s1;
            m_s1 = ~btn;
            old_mode = m_mode;
            m_ch = pass_of(old_mode) ? tch : pat_of(old_mode);
            chg_n = 0;
            if (tick) begin
                eff = samp && m_armed;
                if (!samp) m_armed = 1;
                released = 0;
                pressed_old = m_level;
                if (eff != m_level) begin
                    m_run++;
                    if (m_run == SMP) begin
                        m_run = 0;
                        released = m_level;
                        m_level = eff;
                    end
                end else begin
                    m_run = 0;
                end
                if (released) begin
                    if (m_hold < HOLD) begin
                        m_mode = (m_mode + 1) % NM;
                        chg_n = 1;
                    end
                    m_hold = 0;
                end else if (pressed_old) begin
                    if (m_hold < HOLD) begin
                        m_hold++;
                        if (m_hold == HOLD) begin
                            m_mode = 0;
                            chg_n = 1;
                        end
                    end
                end else begin
                    m_hold = 0;
                end
                if (chg_n) begin
                    m_k = 0;
                    m_led = 0;
                end else begin
                    m_k++;
                    m_led = led_of(m_k - 1, m_mode);
                end
            end
            m_chg = chg_n;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mode", 32'(mode), 32'(m_mode));
            check("mode_changed", 32'(chg), 32'(m_chg));
            check("ch_out", 32'(ch_out), 32'(m_ch));
            check("led", 32'(led), 32'(m_led));
        end
    end

    // Count pulses; the LED must be dark in the cycle the mode changes
    always @(negedge clk) begin
        if (chg === 1'b1) begin
            n_pulse++;
            check("led_dark_on_change", 32'(led), 32'd0);
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(int ticks);
        btn = 1'b0;
        cycles(ticks * DIV);
        btn = 1'b1;
        cycles(30);
    endtask

    initial begin : stim
        int lit, rises;
        logic prev;
        int exp_mode[5];
        logic [3:0] exp_ch[5];
        exp_mode = '{0, 1, 2, 3, 4};
        exp_ch   = '{4'h9, 4'hC, 4'h5, 4'hA, 4'hF};

        rst = 1'b1; btn = 1'b1; tch = 4'h0;
        cmp_en = 1'b1;
        cycles(3);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_ch", 32'(ch_out), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_chg", 32'(chg), 32'd0);
        rst = 1'b0;
        cycles(1);
        check("ch_mode0_first_edge", 32'(ch_out), 32'h9);
        cycles(20);

        // Clean 10-tick press: mode 0 -> 1 (passthrough)
        n_pulse = 0;
        press(10);
        check("clean_press_pulses", 32'(n_pulse), 32'd1);
        check("clean_press_mode", 32'(mode), 32'd1);
        tch = 4'h6;
        cycles(1);
        check("passthru_6", 32'(ch_out), 32'h6);
        tch = 4'hC;
        cycles(1);
        check("passthru_C", 32'(ch_out), 32'hC);

        // Bouncing button, then stable press: one advance to mode 2
        n_pulse = 0;
        for (int i = 0; i < 8; i++) begin
            btn = (i % 2 == 1) ? 1'b1 : 1'b0;
            cycles(DIV);
        end
        btn = 1'b0;
        cycles(10 * DIV);
        btn = 1'b1;
        cycles(30);
        check("bounce_pulses", 32'(n_pulse), 32'd1);
        check("bounce_mode", 32'(mode), 32'd2);
        check("mode2_pattern", 32'(ch_out), 32'h5);

        // Mode 2 LED: one 18-tick period holds 3 flashes of 2 lit ticks
        cycles(20);
        lit = 0; rises = 0; prev = led;
        for (int i = 0; i < 18 * DIV; i++) begin
            cycles(1);
            if (led) lit++;
            if (led && !prev) rises++;
            prev = led;
        end
        check("led_lit_cycles", 32'(lit), 32'(3 * FON * DIV));
        check("led_flashes", 32'(rises), 32'd3);

        // Advance to mode 3, then hold 30 ticks: back to 0 once, no advance on release
        press(8);
        check("to_mode3", 32'(mode), 32'd3);
        n_pulse = 0;
        btn = 1'b0;
        cycles(30 * DIV);
        check("hold_pulses", 32'(n_pulse), 32'd1);
        check("hold_mode", 32'(mode), 32'd0);
        btn = 1'b1;
        cycles(30);
        check("hold_release_pulses", 32'(n_pulse), 32'd1);
        check("hold_release_mode", 32'(mode), 32'd0);

        // Reach mode 4, then five presses wrap through 0..4
        for (int i = 0; i < 4; i++) press(8);
        check("to_mode4", 32'(mode), 32'd4);
        for (int i = 0; i < 5; i++) begin
            press(8);
            check("wrap_mode", 32'(mode), 32'(exp_mode[i]));
            check("wrap_ch", 32'(ch_out), 32'(exp_ch[i]));
        end

        // Reset while mode 3 with the button held; no change after release
        for (int i = 0; i < 4; i++) press(8);
        check("to_mode3_again", 32'(mode), 32'd3);
        btn = 1'b0;
        cycles(10 * DIV);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_ch", 32'(ch_out), 32'd0);
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_chg", 32'(chg), 32'd0);
        cycles(3);
        rst = 1'b0;
        n_pulse = 0;
        cycles(15 * DIV);
        check("held_after_rst_mode", 32'(mode), 32'd0);
        btn = 1'b1;
        cycles(40);
        check("post_rst_release_mode", 32'(mode), 32'd0);
        check("post_rst_release_pulses", 32'(n_pulse), 32'd0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mode_output_sequencer.md
MODE_OUTPUT_SEQUENCER -- requirements
Module: mode_output_sequencer

Interface
Parameters:
REQ-001 NUM_MODES, 5, number of operating modes, range 2..16.
REQ-002 NUM_CH, 4, number of gated output channels, range 1..8.
REQ-003 MODE_PATTERNS, {5'b...}, NUM_MODES*NUM_CH-bit static level per mode/channel; bits [m*NUM_CH +: NUM_CH] belong to mode m.
REQ-004 PASSTHRU_MASK, 5'b00010, one bit per mode; 1 = channels follow timer_ch instead of the pattern.
REQ-005 DEBOUNCE_DIV, 256, clk_2M5 cycles per sample tick (100 us).
REQ-006 DEBOUNCE_SAMPLES, 4, consecutive equal samples needed to change the debounced level.
REQ-007 HOLD_TICKS, 20000, press duration in ticks that forces a return to mode 0.
REQ-008 FLASH_ON / FLASH_OFF / PAUSE, 1000 / 1000 / 5000, LED timing in ticks.

Ports:
REQ-009 clk_2M5  in  1  sole clock; all state updates on its rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 mode_button  in  1  raw button, low = pressed, asynchronous to clk_2M5.
REQ-012 timer_ch  in  NUM_CH  timing-generator channel outputs.
REQ-013 ch_out  out  NUM_CH  registered channel outputs to the pins.
REQ-014 LED_output  out  1  registered mode indicator, high = lit.
REQ-015 mode  out  clog2(NUM_MODES)  current mode index.
REQ-016 mode_changed  out  1  one-cycle pulse on every mode update.

Function
REQ-017 mode_button SHALL pass through a 2-flop synchroniser before any use.
REQ-018 A prescaler SHALL assert a one-cycle tick every DEBOUNCE_DIV cycles, free-running from reset.
REQ-019 The debounced press level SHALL change only after DEBOUNCE_SAMPLES consecutive ticks sample the opposite synchronised level; any mismatch restarts the count.
REQ-020 The hold counter SHALL count ticks while the debounced level is pressed, saturate at HOLD_TICKS, and clear on release.
REQ-021 When the hold counter reaches HOLD_TICKS, mode SHALL become 0 on that tick, exactly once per press.
REQ-022 On a debounced release with hold count < HOLD_TICKS, mode SHALL advance by 1, wrapping NUM_MODES-1 -> 0.
REQ-023 A release following a hold return SHALL NOT advance the mode.
REQ-024 mode_changed SHALL pulse in the same cycle mode updates, including a hold return when the mode is already 0.
REQ-025 ch_out SHALL equal timer_ch (when PASSTHRU_MASK[mode]=1) or the MODE_PATTERNS slice for the mode, registered; latency 1 cycle from timer_ch or from mode.
REQ-026 LED sequence for mode m: (m+1) flashes, each FLASH_ON ticks lit then FLASH_OFF ticks dark, then PAUSE further dark ticks, repeating.
REQ-027 On mode_changed, the LED sequencer SHALL restart with LED dark; the first flash starts on the next tick.
REQ-028 The LED counter and flash counter SHALL be wide enough for the maximum parameter values without wrap-around.

Reset
REQ-029 During reset, mode=0, ch_out=0, LED_output=0, mode_changed=0, and all counters, the synchroniser and the debounced level (released) SHALL clear.
REQ-030 After reset deasserts, ch_out SHALL reflect mode 0 on the first clock edge.
REQ-031 Reset asserted mid-press SHALL discard the press; a button still held at deassertion SHALL be debounced afresh and produce no mode change until it is released.

Verification
Params: NUM_MODES=5, NUM_CH=4, DEBOUNCE_DIV=4, DEBOUNCE_SAMPLES=3, HOLD_TICKS=20, FLASH_ON=2, FLASH_OFF=2, PAUSE=6.
REQ-032 Clean press of 10 ticks, then release -> exactly one mode_changed; mode 0->1; ch_out follows timer_ch 1 cycle later.
REQ-033 Button bouncing every 1 tick for 8 ticks, then stable low 10 ticks and released -> exactly one advance.
REQ-034 Five short presses from mode 4 -> sequence 0,1,2,3,4 after wrap; ch_out matches the MODE_PATTERNS slice each time.
REQ-035 Press held 30 ticks in mode 3 -> mode=0 at hold tick 20, one pulse; release -> no further change.
REQ-036 Mode 2 steady -> LED high 2 ticks, low 2 ticks, repeated 3 times, then 6 further low ticks, period 18 ticks; a mode change mid-flash restarts it dark.
REQ-037 Reset pulse while mode=3 and button held -> all outputs 0 immediately; after release of the button, mode stays 0.
